// File: rtl/sudoku_grid_loader.sv
// 9x9 grid register file written one cell per cycle over valid/ready.
// Drives the packed puzzle_ans bus and tracks filled cells and grid completeness.
module sudoku_grid_loader #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [3:0]           wr_row,
  input  logic [3:0]           wr_col,
  input  logic [WIDTH-1:0]     wr_value,
  output logic [81*WIDTH-1:0]  puzzle_ans,
  output logic [6:0]           filled_count,
  output logic                 grid_full,
  output logic                 full_pulse,
  output logic                 err_addr
);

  typedef enum logic [1:0] {EMPTY, LOADING, FULL} state_t;

  logic [80:0][WIDTH-1:0] cells_q, cells_d;
  logic [6:0]             count_q, count_d;
  state_t                 state_q, state_d;
  logic                   full_pulse_q, full_pulse_d;
  logic                   err_q, err_d;
  logic                   hs, addr_ok;
  logic [6:0]             idx;
  logic [WIDTH-1:0]       old_val;

  assign wr_ready = rst_n & ~clear;
  assign hs       = wr_valid & wr_ready;
  assign addr_ok  = (wr_row <= 4'd8) && (wr_col <= 4'd8);
  // Only meaningful when addr_ok; illegal addresses may overflow 7 bits.
  assign idx      = 7'(wr_row) * 7'd9 + 7'(wr_col);

  always_comb begin
    old_val = '0;
    for (int i = 0; i < 81; i++)
      if (idx == 7'(i)) old_val = cells_q[i];
  end

  always_comb begin
    cells_d      = cells_q;
    count_d      = count_q;
    state_d      = state_q;
    err_d        = 1'b0;
    full_pulse_d = 1'b0;
    if (clear) begin
      cells_d = '0;
      count_d = 7'd0;
      state_d = EMPTY;
    end else begin
      if (hs) begin
        if (!addr_ok) begin
          err_d = 1'b1;
        end else begin
          for (int i = 0; i < 81; i++)
            if (idx == 7'(i)) cells_d[i] = wr_value;
          if (~|old_val && |wr_value)      count_d = count_q + 7'd1;
          else if (|old_val && ~|wr_value) count_d = count_q - 7'd1;
        end
      end
      case (state_q)
        EMPTY:   if (count_d != 7'd0) state_d = LOADING;
        LOADING: if (count_d == 7'd81) state_d = FULL;
                 else if (count_d == 7'd0) state_d = EMPTY;
        FULL:    if (count_d != 7'd81) state_d = LOADING;
        default: state_d = EMPTY;
      endcase
      full_pulse_d = (state_d == FULL) && (state_q != FULL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cells_q      <= '0;
      count_q      <= 7'd0;
      state_q      <= EMPTY;
      full_pulse_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cells_q      <= cells_d;
      count_q      <= count_d;
      state_q      <= state_d;
      full_pulse_q <= full_pulse_d;
      err_q        <= err_d;
    end
  end

  assign puzzle_ans   = cells_q;
  assign filled_count = count_q;
  assign grid_full    = (state_q == FULL);
  assign full_pulse   = full_pulse_q;
  assign err_addr     = err_q;

endmodule
